// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control slice: instruction field
// positions, NOP, forwarding-select encodings and opcode-class helpers.
package pipe_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 20;
  localparam int SRC1_MSB = 19;
  localparam int SRC1_LSB = 16;
  localparam int SRC2_MSB = 15;
  localparam int SRC2_LSB = 12;

  localparam logic [31:0] NOP = 32'h0;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef enum logic [1:0] {
    UPD_NORMAL,
    UPD_STALL,
    UPD_FLUSH,
    UPD_FREEZE
  } upd_e;

  function automatic logic [7:0] op_of(input logic [31:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [3:0] dest_of(input logic [31:0] ins);
    return ins[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [3:0] src1_of(input logic [31:0] ins);
    return ins[SRC1_MSB:SRC1_LSB];
  endfunction

  function automatic logic [3:0] src2_of(input logic [31:0] ins);
    return ins[SRC2_MSB:SRC2_LSB];
  endfunction

  function automatic logic writes_reg(input logic [31:0] ins);
    logic [7:0] op;
    op = op_of(ins);
    return (op[5:3] != 3'b000) && (op[6:3] != 4'b1000);
  endfunction

  function automatic logic is_load(input logic [31:0] ins);
    logic [7:0] op;
    op = op_of(ins);
    return op[6:3] == 4'b1001;
  endfunction

  function automatic logic is_store(input logic [31:0] ins);
    logic [7:0] op;
    op = op_of(ins);
    return op[6:3] == 4'b1000;
  endfunction

  function automatic logic uses_src1(input logic [31:0] ins);
    logic [7:0] op;
    op = op_of(ins);
    return op[2];
  endfunction

  function automatic logic uses_src2(input logic [31:0] ins);
    return op_of(ins) != 8'h00;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational load-use stall and D-operand forwarding selects from the
// registered D/E/M/W opcodes; zero latency, no flow control of its own.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  logic [31:0] opcode_D,
  input  logic [31:0] opcode_E,
  input  logic [31:0] opcode_M,
  input  logic [31:0] opcode_W,
  output logic        stall,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b
);

  function automatic logic dest_hit(input logic [31:0] stage, input logic [3:0] src);
    return writes_reg(stage) && (dest_of(stage) == src) &&
           !((ZERO_REG != 0) && (src == 4'd0));
  endfunction

  // A load in E has no result yet, so it falls through to older stages.
  function automatic logic [1:0] pick(input logic [3:0] src);
    if (dest_hit(opcode_E, src) && !is_load(opcode_E)) return FWD_E;
    else if (dest_hit(opcode_M, src))                   return FWD_M;
    else if (dest_hit(opcode_W, src))                   return FWD_W;
    else                                                return FWD_RF;
  endfunction

  always_comb begin
    fwd_sel_a = pick(src1_of(opcode_D));
    fwd_sel_b = pick(src2_of(opcode_D));
    stall     = is_load(opcode_E) && writes_reg(opcode_E) &&
                ((uses_src1(opcode_D) && dest_hit(opcode_E, src1_of(opcode_D))) ||
                 (uses_src2(opcode_D) && dest_hit(opcode_E, src2_of(opcode_D))));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: owns ip and D/E/M/W opcodes; freeze > flush > stall > advance.
// Fetch-to-W latency 4 cycles plus one per stall/freeze; PIPE_CTRL_PERF_EN adds saturating counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int                 IADDR_W   = 8,
  parameter logic [IADDR_W-1:0] RESET_VEC = '0,
  parameter int                 ZERO_REG  = 1,
  parameter int                 CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  output logic [IADDR_W-1:0] imem_addr,
  output logic               imem_rden,
  input  logic               branch_taken,
  input  logic [IADDR_W-1:0] branch_target,
  input  logic               ex_busy,
  output logic [31:0]        opcode_D,
  output logic [31:0]        opcode_E,
  output logic [31:0]        opcode_M,
  output logic [31:0]        opcode_W,
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
  output logic               stall,
  output logic               freeze,
  output logic               flush,
  output logic [CNT_W-1:0]   cnt_cycles,
  output logic [CNT_W-1:0]   cnt_stall,
  output logic [CNT_W-1:0]   cnt_flush
);

  logic [IADDR_W-1:0] ip;
  logic               stall_raw;
  upd_e               upd;

  pipe_hazard_unit #(.ZERO_REG(ZERO_REG)) u_hazard (
    .opcode_D  (opcode_D),
    .opcode_E  (opcode_E),
    .opcode_M  (opcode_M),
    .opcode_W  (opcode_W),
    .stall     (stall_raw),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b)
  );

  always_comb begin
    upd = UPD_NORMAL;
    if (ex_busy)           upd = UPD_FREEZE;
    else if (branch_taken) upd = UPD_FLUSH;
    else if (stall_raw)    upd = UPD_STALL;
  end

  assign freeze    = ex_busy;
  assign flush     = branch_taken & ~ex_busy;
  assign stall     = (upd == UPD_STALL);
  assign imem_rden = ~(freeze | stall);
  assign imem_addr = ip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip       <= RESET_VEC;
      opcode_D <= NOP;
      opcode_E <= NOP;
      opcode_M <= NOP;
      opcode_W <= NOP;
    end else begin
      opcode_W <= opcode_M;
      case (upd)
        UPD_FREEZE: opcode_M <= NOP;
        UPD_FLUSH: begin
          ip       <= branch_target;
          opcode_D <= NOP;
          opcode_E <= NOP;
          opcode_M <= opcode_E;
        end
        UPD_STALL: begin
          opcode_E <= NOP;
          opcode_M <= opcode_E;
        end
        default: begin
          ip       <= ip + {{(IADDR_W-1){1'b0}}, 1'b1};
          opcode_D <= instr;
          opcode_E <= opcode_D;
          opcode_M <= opcode_E;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_q, stl_q, fls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else begin
      if (cyc_q != CNT_MAX)                      cyc_q <= cyc_q + CNT_ONE;
      if ((stall | freeze) && (stl_q != CNT_MAX)) stl_q <= stl_q + CNT_ONE;
      if (flush && (fls_q != CNT_MAX))           fls_q <= fls_q + CNT_ONE;
    end
  end

  assign cnt_cycles = cyc_q;
  assign cnt_stall  = stl_q;
  assign cnt_flush  = fls_q;
`else
  assign cnt_cycles = '0;
  assign cnt_stall  = '0;
  assign cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, fetch flow, load-use stall, forwarding,
// branch flush, freeze with ignored branch, ip wrap, counters, async reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [7:0]  imem_addr;
  logic        imem_rden;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        ex_busy;
  logic [31:0] opcode_D, opcode_E, opcode_M, opcode_W;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall, freeze, flush;
  logic [3:0]  cnt_cycles, cnt_stall, cnt_flush;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A    = 32'h0810_0000; // op 08 dest 1
  localparam logic [31:0] L    = 32'h4C30_0000; // load dest 3
  localparam logic [31:0] U    = 32'h0C03_0000; // uses src1=3
  localparam logic [31:0] P    = 32'h0850_0000; // op 08 dest 5
  localparam logic [31:0] Q    = 32'h0800_5000; // dest 0, src2=5
  localparam logic [31:0] R    = 32'h0800_0000; // dest 0, src2=0
  localparam logic [31:0] T    = 32'h1020_0000;
  localparam logic [31:0] V    = 32'h1830_0000;
  localparam logic [31:0] S    = 32'h2040_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  pipe_ctrl #(.IADDR_W(8), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .imem_addr     (imem_addr),
    .imem_rden     (imem_rden),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ex_busy       (ex_busy),
    .opcode_D      (opcode_D),
    .opcode_E      (opcode_E),
    .opcode_M      (opcode_M),
    .opcode_W      (opcode_W),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b),
    .stall         (stall),
    .freeze        (freeze),
    .flush         (flush),
    .cnt_cycles    (cnt_cycles),
    .cnt_stall     (cnt_stall),
    .cnt_flush     (cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    instr         = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    ex_busy       = 1'b0;
    #12;
    chk("rst_ip", 32'(imem_addr), 32'h0);
    chk("rst_D", opcode_D, 32'h0);
    chk("rst_E", opcode_E, 32'h0);
    chk("rst_M", opcode_M, 32'h0);
    chk("rst_W", opcode_W, 32'h0);
    chk("rst_cnt", 32'({cnt_cycles, cnt_stall, cnt_flush}), 32'h0);
    reset = 1'b0;

    // free-running fetch
    for (int k = 0; k < 5; k++) begin
      instr = A;
      #1;
      chk("run_ip", 32'(imem_addr), 32'(k));
      chk("run_fwd", 32'({fwd_sel_a, fwd_sel_b}), 32'h0);
      if (k == 4) chk("run_W", opcode_W, A);
      tick();
    end

    // load-use: L then U
    instr = L; #1;
    chk("pre_stall", 32'(stall), 32'h0);
    tick();
    instr = U; tick();
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_rden", 32'(imem_rden), 32'h0);
    chk("lu_ip", 32'(imem_addr), 32'h7);
    chk("lu_fwdA_E_load", 32'(fwd_sel_a), 32'h0);
    tick();
    chk("lu_stall_off", 32'(stall), 32'h0);
    chk("lu_E_nop", opcode_E, 32'h0);
    chk("lu_D_hold", opcode_D, U);
    chk("lu_ip_hold", 32'(imem_addr), 32'h7);
    chk("lu_fwdA_M", 32'(fwd_sel_a), 32'h2);

    // forwarding E/M/W and zero-register exclusion
    instr = P; tick();
    instr = Q; tick();
    chk("fwdB_E", 32'(fwd_sel_b), 32'h1);
    chk("fwd_nostall", 32'(stall), 32'h0);
    instr = Q; tick();
    chk("fwdB_M", 32'(fwd_sel_b), 32'h2);
    instr = Q; tick();
    chk("fwdB_W", 32'(fwd_sel_b), 32'h3);
    instr = R; tick();
    chk("fwdB_zero", 32'(fwd_sel_b), 32'h0);
    chk("fwdA_zero", 32'(fwd_sel_a), 32'h0);
    chk("fwd_ip", 32'(imem_addr), 32'hC);

    // branch to 0x10, then branch at 0x10 to 0x40
    branch_taken = 1'b1; branch_target = 8'h10; instr = JUNK; #1;
    chk("br1_flush", 32'(flush), 32'h1);
    chk("br1_freeze", 32'(freeze), 32'h0);
    tick();
    branch_target = 8'h40; #1;
    chk("br2_ip", 32'(imem_addr), 32'h10);
    chk("br2_D", opcode_D, 32'h0);
    chk("br2_E", opcode_E, 32'h0);
    chk("br2_M", opcode_M, Q);
    chk("br2_flush", 32'(flush), 32'h1);
    tick();
    branch_taken = 1'b0; instr = T; #1;
    chk("br_tgt_ip", 32'(imem_addr), 32'h40);
    chk("br_flush_off", 32'(flush), 32'h0);
    chk("br_D_nop", opcode_D, 32'h0);
    chk("br_E_nop", opcode_E, 32'h0);
    chk("br_rden", 32'(imem_rden), 32'h1);
    tick();
    chk("br_tgt_D", opcode_D, T);
    instr = V; tick();
    instr = S; tick();

    // freeze 3 cycles, branch pulsed in the middle
    ex_busy = 1'b1; instr = JUNK; branch_target = 8'h99;
    for (int f = 0; f < 3; f++) begin
      branch_taken = (f == 1);
      #1;
      chk("frz_freeze", 32'(freeze), 32'h1);
      chk("frz_flush", 32'(flush), 32'h0);
      chk("frz_stall", 32'(stall), 32'h0);
      chk("frz_rden", 32'(imem_rden), 32'h0);
      tick();
      chk("frz_ip", 32'(imem_addr), 32'h43);
      chk("frz_D", opcode_D, S);
      chk("frz_E", opcode_E, V);
      chk("frz_M", opcode_M, 32'h0);
      chk("frz_W", opcode_W, (f == 0) ? T : 32'h0);
    end
    ex_busy = 1'b0; branch_taken = 1'b0; instr = A; #1;
    chk("frz_end_ip", 32'(imem_addr), 32'h43);
    chk("frz_end_freeze", 32'(freeze), 32'h0);

    // ip wrap
    branch_taken = 1'b1; branch_target = 8'hFE; instr = JUNK; tick();
    branch_taken = 1'b0; instr = A; #1;
    chk("wrap_FE", 32'(imem_addr), 32'hFE);
    tick();
    chk("wrap_FF", 32'(imem_addr), 32'hFF);
    tick();
    chk("wrap_00", 32'(imem_addr), 32'h00);

`ifdef PIPE_CTRL_PERF_EN
    chk("cnt_cycles_sat", 32'(cnt_cycles), 32'hF);
    chk("cnt_stall", 32'(cnt_stall), 32'h4);
    chk("cnt_flush", 32'(cnt_flush), 32'h3);
`else
    chk("cnt_cycles_tied", 32'(cnt_cycles), 32'h0);
    chk("cnt_stall_tied", 32'(cnt_stall), 32'h0);
    chk("cnt_flush_tied", 32'(cnt_flush), 32'h0);
`endif

    // asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ip", 32'(imem_addr), 32'h0);
    chk("arst_D", opcode_D, 32'h0);
    chk("arst_W", opcode_W, 32'h0);
    chk("arst_cnt", 32'(cnt_cycles), 32'h0);
    #10;
    reset = 1'b0;
    #10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the next-generation 5-stage (I/D/E/M/W) core. It owns the instruction pointer and the D/E/M/W opcode pipeline registers, and generates the pipeline hazard and redirect controls:
- operand-forwarding selects for the D stage
- load-use stall
- multi-cycle-execute freeze
- branch redirect and flush

It sits between instruction memory and the datapath (register file, ALU, data memory), which consume its opcode and select outputs.

Parameters:
IADDR_W, 8, instruction-address width; ip wraps modulo 2^IADDR_W.
RESET_VEC, 0, ip value after reset.
ZERO_REG, 1, when 1 register index 0 never produces a hazard or a forward.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
instr  in  32  instruction at imem_addr, valid in the same cycle
imem_addr  out  IADDR_W  current ip
imem_rden  out  1  instruction-memory read enable
branch_taken  in  1  branch resolved taken in D this cycle
branch_target  in  IADDR_W  redirect address
ex_busy  in  1  multi-cycle execute unit (mul/div) not finished
opcode_D, opcode_E, opcode_M, opcode_W  out  32 each  pipeline instruction registers
fwd_sel_a, fwd_sel_b  out  2 each  D-operand source: 0 regfile, 1 E result, 2 M result, 3 W result
stall  out  1  load-use stall active
freeze  out  1  ex_busy freeze active
flush  out  1  branch flush active
cnt_cycles, cnt_stall, cnt_flush  out  CNT_W each  performance counters

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is high: ip=RESET_VEC; all opcode registers=32'h0 (NOP); counters=0. Reset asserted mid-operation clears the pipeline immediately, with no drain.
- Instruction fields:
  - [31:24] op
  - [23:20] dest
  - [19:16] src1, used only when op[2]=1
  - [15:12] src2, used whenever op!=0
- Opcode classes:
  - writes_reg = op[5:3]!=0 and op[6:3]!=4'b1000
  - is_load = op[6:3]==4'b1001
  - is_store = op[6:3]==4'b1000
- Load-use stall: stall = is_load(E) and writes_reg(E) and E.dest matches a used source of D, excluding dest 0 when ZERO_REG=1.
- Forwarding, per D operand, first match wins:
  - E: only if E is not a load; sel 1
  - M: sel 2
  - W: sel 3
  - otherwise 0
  - A stage matches only if writes_reg is true for it and its dest equals the operand's source index (index 0 excluded when ZERO_REG=1).
  - Selects are combinational from the registered opcodes.
- Sequential update, in priority order:
  1. freeze (ex_busy=1): ip, D, E hold; M<=NOP; W<=M. Any branch_taken in the same cycle is ignored; the datapath re-asserts it after the freeze.
  2. flush (branch_taken=1, ex_busy=0): ip<=branch_target; D<=NOP; E<=NOP; M<=E; W<=M.
  3. stall (load-use): ip, D hold; E<=NOP; M<=E; W<=M.
  4. normal: ip<=ip+1 (wraps, 2^IADDR_W-1 -> 0); D<=instr; E<=D; M<=E; W<=M.
- Status outputs: flush=branch_taken&~ex_busy; stall is masked to 0 during freeze or flush; freeze=ex_busy.
- imem_rden = ~(freeze|stall).
- Latency: an instruction fetched in cycle n is in D at n+1, E at n+2, M at n+3, W at n+4, plus one cycle per stall or freeze.
- Branch redirect: instr presented in the flush cycle is discarded. The target instruction enters D two cycles after the branch was in D.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: each counter saturates at 2^CNT_W-1.
  - cnt_cycles increments every non-reset cycle.
  - cnt_stall increments on stall or freeze.
  - cnt_flush increments on flush.
- Undefined: the counter ports remain and are tied to 0, and no counter registers are inferred.

Decomposition:
- Package pipe_pkg:
  - field bit positions
  - NOP constant 32'h0
  - FWD_RF/FWD_E/FWD_M/FWD_W encodings
  - functions writes_reg, is_load, is_store, uses_src1
- One combinational sub-module, pipe_hazard_unit: computes stall, fwd_sel_a and fwd_sel_b from the four opcodes. pipe_ctrl holds all state.

Test Plan:
- Reset then 5 free-running cycles with instr=32'h08100000 (op 0x08, dest 1) -> imem_addr 0,1,2,3,4; opcode_W=32'h08100000 in cycle 4; fwd selects 0.
- E=op 0x4C dest 3 (load), D=op 0x0C src1 3 -> stall=1 for exactly 1 cycle, ip held, E=NOP next cycle, then fwd_sel_a=2.
- E=op 0x08 dest 5, D src2=5 -> fwd_sel_b=1. Same case with dest 0 and ZERO_REG=1 -> fwd_sel_b=0.
- branch_taken=1, target 8'h40, at ip 8'h10 -> next imem_addr=8'h40; D and E become NOP; flush=1 for one cycle.
- ex_busy high 3 cycles with branch_taken pulsed mid-freeze -> ip, D, E unchanged; 3 NOPs enter M; branch ignored.
- ip=8'hFF in normal flow -> next imem_addr=8'h00. With PIPE_CTRL_PERF_EN and CNT_W=4: after 20 cycles cnt_cycles=15 (saturated).
